tnn_neuron_sequencer: RTL and testbench



---
 rtl/tnn_neuron_sequencer.sv | 151 +++++++++++++++
 tb/tb_tnn_neuron_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tnn_neuron_sequencer.sv
// Time-multiplexes one 7-slot ternary neuron core across a whole TNN layer,
// routing features per neuron from a programmable table and collecting result bits.
module tnn_neuron_sequencer #(
    parameter int N_NEURONS = 8,
    localparam int NW = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_we,
    input  logic [NW-1:0]        cfg_neuron,
    input  logic [2:0]           cfg_slot,
    input  logic [2:0]           cfg_sel,
    output logic                 cfg_err,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [13:0]          in_feat,
    output logic [13:0]          core_in,
    input  logic                 core_out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N_NEURONS-1:0] out_bits,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        OUT
    } state_t;

    state_t                state_q, state_d;
    logic [NW-1:0]         idx_q, idx_d;
    logic [13:0]           feat_q, feat_d;
    logic [13:0]           core_in_q, core_in_d;
    logic [N_NEURONS-1:0]  bits_q, bits_d;
    logic                  cfg_err_q, cfg_err_d;
    logic                  in_ready_q, in_ready_d;
    logic                  out_valid_q, out_valid_d;
    logic                  busy_q, busy_d;
    logic                  wr_ok;

    // One row per neuron; slot s selector lives at [3s+2:3s], 7 = drive zero.
    logic [20:0]           tbl_q [N_NEURONS];
    logic [20:0]           tbl_d [N_NEURONS];

    function automatic logic [13:0] route(input logic [13:0] f,
                                          input logic [20:0] row);
        logic [13:0] r;
        int          sel;
        r = '0;
        for (int s = 0; s < 7; s++) begin
            sel = int'(row[3*s +: 3]);
            if (sel != 7) begin
                r[2*s +: 2] = f[2*sel +: 2];
            end
        end
        return r;
    endfunction

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        feat_d    = feat_q;
        core_in_d = core_in_q;
        bits_d    = bits_q;
        tbl_d     = tbl_q;
        cfg_err_d = 1'b0;

        wr_ok = cfg_we && (state_q == IDLE) && (cfg_slot != 3'd7)
                && (int'(cfg_neuron) < N_NEURONS);
        if (wr_ok) begin
            tbl_d[cfg_neuron][3*int'(cfg_slot) +: 3] = cfg_sel;
        end
        cfg_err_d = cfg_we && !wr_ok;

        unique case (state_q)
            IDLE: begin
                core_in_d = '0;
                if (in_valid) begin
                    feat_d    = in_feat;
                    idx_d     = '0;
                    bits_d    = '0;
                    // Uses tbl_d so a same-edge write is already visible.
                    core_in_d = route(in_feat, tbl_d[0]);
                    state_d   = RUN;
                end
            end
            RUN: begin
                bits_d[idx_q] = core_out;
                if (idx_q == NW'(N_NEURONS - 1)) begin
                    state_d   = OUT;
                    core_in_d = '0;
                end else begin
                    idx_d     = idx_q + NW'(1);
                    core_in_d = route(feat_q, tbl_q[idx_d]);
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d   = IDLE;
                core_in_d = '0;
            end
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == OUT);
        busy_d      = (state_d == RUN) || (state_d == OUT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            feat_q      <= '0;
            core_in_q   <= '0;
            bits_q      <= '0;
            cfg_err_q   <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            for (int n = 0; n < N_NEURONS; n++) begin
                tbl_q[n] <= {7{3'd7}};
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            feat_q      <= feat_d;
            core_in_q   <= core_in_d;
            bits_q      <= bits_d;
            cfg_err_q   <= cfg_err_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            for (int n = 0; n < N_NEURONS; n++) begin
                tbl_q[n] <= tbl_d[n];
            end
        end
    end

    assign cfg_err   = cfg_err_q;
    assign in_ready  = in_ready_q;
    assign core_in   = core_in_q;
    assign out_valid = out_valid_q;
    assign out_bits  = bits_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_tnn_neuron_sequencer.sv
// Directed bench for tnn_neuron_sequencer with an exact-comparator core model
// (a+c+e > b+d+f+g); covers N_NEURONS=8 and N_NEURONS=1 instances.
module tb_tnn_neuron_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic [2:0]  cfg_neuron;
    logic [2:0]  cfg_slot;
    logic [2:0]  cfg_sel;
    logic        cfg_err;
    logic        in_valid;
    logic        in_ready;
    logic [13:0] in_feat;
    logic [13:0] core_in;
    logic        core_out;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_bits;
    logic        busy;

    logic        cfg_we1;
    logic [0:0]  cfg_neuron1;
    logic [2:0]  cfg_slot1;
    logic [2:0]  cfg_sel1;
    logic        cfg_err1;
    logic        in_valid1;
    logic        in_ready1;
    logic [13:0] in_feat1;
    logic [13:0] core_in1;
    logic        core_out1;
    logic        out_valid1;
    logic        out_ready1;
    logic [0:0]  out_bits1;
    logic        busy1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    function automatic logic tcore(input logic [13:0] c);
        int p;
        int n;
        p = int'(c[1:0]) + int'(c[5:4]) + int'(c[9:8]);
        n = int'(c[3:2]) + int'(c[7:6]) + int'(c[11:10]) + int'(c[13:12]);
        return p > n;
    endfunction

    assign core_out  = tcore(core_in);
    assign core_out1 = tcore(core_in1);

    tnn_neuron_sequencer #(.N_NEURONS(8)) dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_neuron(cfg_neuron), .cfg_slot(cfg_slot),
        .cfg_sel(cfg_sel), .cfg_err(cfg_err),
        .in_valid(in_valid), .in_ready(in_ready), .in_feat(in_feat),
        .core_in(core_in), .core_out(core_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_bits(out_bits),
        .busy(busy)
    );

    tnn_neuron_sequencer #(.N_NEURONS(1)) dut1 (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we1), .cfg_neuron(cfg_neuron1), .cfg_slot(cfg_slot1),
        .cfg_sel(cfg_sel1), .cfg_err(cfg_err1),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_feat(in_feat1),
        .core_in(core_in1), .core_out(core_out1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_bits(out_bits1),
        .busy(busy1)
    );

    task automatic cfg_write(input logic [2:0] n, input logic [2:0] s,
                             input logic [2:0] sel, output logic err);
        cfg_we = 1'b1;
        cfg_neuron = n;
        cfg_slot = s;
        cfg_sel = sel;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        err = cfg_err;
    endtask

    // Sends one vector from IDLE, waits for the result and completes the handshake.
    task automatic run_vec(input logic [13:0] f, output logic [7:0] bits,
                           output int lat, output logic [13:0] ci0);
        in_feat = f;
        in_valid = 1'b1;
        lat = -1;
        ci0 = '0;
        bits = '0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (i == 1) begin
                in_valid = 1'b0;
                ci0 = core_in;
            end
            if (out_valid) begin
                lat = i;
                bits = out_bits;
                break;
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0]  b;
        int          lat;
        logic [13:0] ci;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_bits !== 8'h00) begin failures++; $display("FAIL reset_out_bits got=%h exp=00", out_bits); end
        checks++; if (core_in !== 14'h0) begin failures++; $display("FAIL reset_core_in got=%h exp=0", core_in); end
        checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL reset_cfg_err got=%b exp=0", cfg_err); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        run_vec(14'h3FFF, b, lat, ci);
        checks++; if (b !== 8'h00) begin failures++; $display("FAIL reset_zero_table got=%h exp=00", b); end
        checks++; if (lat !== 9) begin failures++; $display("FAIL reset_latency got=%0d exp=9", lat); end
    endtask

    task automatic test_single();
        logic        err;
        logic        errs;
        logic [7:0]  b;
        int          lat;
        logic [13:0] ci;
        errs = 1'b0;
        for (int s = 0; s < 7; s++) begin
            cfg_write(3'd0, 3'(s), 3'(s), err);
            errs = errs | err;
        end
        checks++; if (errs !== 1'b0) begin failures++; $display("FAIL single_cfg_err got=%b exp=0", errs); end
        run_vec(14'h0333, b, lat, ci);
        checks++; if (b !== 8'h01) begin failures++; $display("FAIL single_bits got=%h exp=01", b); end
        checks++; if (lat !== 9) begin failures++; $display("FAIL single_latency got=%0d exp=9", lat); end
        checks++; if (ci !== 14'h0333) begin failures++; $display("FAIL single_core_in got=%h exp=0333", ci); end
    endtask

    task automatic test_routing();
        logic        err;
        logic [7:0]  b;
        int          lat;
        logic [13:0] ci;
        cfg_write(3'd5, 3'd0, 3'd6, err);
        cfg_write(3'd5, 3'd2, 3'd6, err);
        cfg_write(3'd5, 3'd4, 3'd7, err);
        cfg_write(3'd5, 3'd1, 3'd1, err);
        cfg_write(3'd5, 3'd3, 3'd1, err);
        cfg_write(3'd5, 3'd5, 3'd1, err);
        cfg_write(3'd5, 3'd6, 3'd1, err);
        run_vec(14'h2004, b, lat, ci);
        checks++; if (b !== 8'h00) begin failures++; $display("FAIL route_tie got=%h exp=00", b); end
        checks++; if (ci !== 14'h2004) begin failures++; $display("FAIL route_core_in0 got=%h exp=2004", ci); end
        run_vec(14'h3004, b, lat, ci);
        checks++; if (b !== 8'h20) begin failures++; $display("FAIL route_win got=%h exp=20", b); end
    endtask

    task automatic test_back_to_back();
        logic stable;
        in_feat = 14'h0333;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_feat = 14'h3004;
        checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("FAIL b2b_accept busy=%b in_ready=%b exp=1/0", busy, in_ready); end
        for (int i = 0; i < 40; i++) begin
            if (out_valid) break;
            @(posedge clk); #1;
        end
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL b2b_timeout1 out_valid=%b exp=1", out_valid); end
        stable = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            if (out_bits !== 8'h01 || out_valid !== 1'b1 || in_ready !== 1'b0) stable = 1'b0;
        end
        checks++; if (stable !== 1'b1) begin failures++; $display("FAIL b2b_hold bits=%h valid=%b ready=%b exp=01/1/0", out_bits, out_valid, in_ready); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL b2b_release in_ready=%b out_valid=%b exp=1/0", in_ready, out_valid); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_second_accept busy=%b exp=1", busy); end
        for (int i = 0; i < 40; i++) begin
            if (out_valid) break;
            @(posedge clk); #1;
        end
        checks++; if (out_bits !== 8'h20 || out_valid !== 1'b1) begin failures++; $display("FAIL b2b_second got=%h valid=%b exp=20/1", out_bits, out_valid); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_cfg_reject();
        logic        err;
        logic [7:0]  b;
        int          lat;
        logic [13:0] ci;
        in_feat = 14'h0333;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cfg_write(3'd1, 3'd0, 3'd0, err);
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL rej_run_pulse got=%b exp=1", err); end
        @(posedge clk); #1;
        checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL rej_run_one_cycle got=%b exp=0", cfg_err); end
        for (int i = 0; i < 40; i++) begin
            if (out_valid) break;
            @(posedge clk); #1;
        end
        checks++; if (out_bits !== 8'h01 || out_valid !== 1'b1) begin failures++; $display("FAIL rej_run_result got=%h valid=%b exp=01/1", out_bits, out_valid); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        cfg_write(3'd1, 3'd7, 3'd0, err);
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL rej_slot7_pulse got=%b exp=1", err); end
        @(posedge clk); #1;
        checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL rej_slot7_one_cycle got=%b exp=0", cfg_err); end
        run_vec(14'h0333, b, lat, ci);
        checks++; if (b !== 8'h01) begin failures++; $display("FAIL rej_table_intact got=%h exp=01", b); end
    endtask

    task automatic test_reset_mid_run();
        logic [7:0]  b;
        int          lat;
        logic [13:0] ci;
        in_feat = 14'h0333;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (out_bits !== 8'h01) begin failures++; $display("FAIL midrun_partial got=%h exp=01", out_bits); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL midrun_idle in_ready=%b busy=%b exp=1/0", in_ready, busy); end
        checks++; if (out_valid !== 1'b0 || out_bits !== 8'h00) begin failures++; $display("FAIL midrun_out valid=%b bits=%h exp=0/00", out_valid, out_bits); end
        checks++; if (core_in !== 14'h0) begin failures++; $display("FAIL midrun_core_in got=%h exp=0", core_in); end
        run_vec(14'h0333, b, lat, ci);
        checks++; if (b !== 8'h00) begin failures++; $display("FAIL midrun_table_reset got=%h exp=00", b); end
        checks++; if (ci !== 14'h0) begin failures++; $display("FAIL midrun_route_zero got=%h exp=0", ci); end
        checks++; if (lat !== 9) begin failures++; $display("FAIL midrun_latency got=%0d exp=9", lat); end
    endtask

    task automatic test_n1();
        int lat;
        logic [0:0] b;
        logic [0:0] exp_b;
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 1) begin
                cfg_we1 = 1'b1;
                cfg_neuron1 = 1'b0;
                cfg_slot1 = 3'd0;
                cfg_sel1 = 3'd0;
                @(posedge clk); #1;
                cfg_we1 = 1'b0;
            end
            exp_b = (pass == 1) ? 1'b1 : 1'b0;
            in_feat1 = 14'h0001;
            in_valid1 = 1'b1;
            lat = -1;
            b = 1'b0;
            for (int i = 1; i <= 10; i++) begin
                @(posedge clk); #1;
                if (i == 1) in_valid1 = 1'b0;
                if (out_valid1) begin
                    lat = i;
                    b = out_bits1;
                    break;
                end
            end
            checks++; if (lat !== 2) begin failures++; $display("FAIL n1_latency pass=%0d got=%0d exp=2", pass, lat); end
            checks++; if (b !== exp_b) begin failures++; $display("FAIL n1_bits pass=%0d got=%b exp=%b", pass, b, exp_b); end
            out_ready1 = 1'b1;
            @(posedge clk); #1;
            out_ready1 = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1;
        cfg_we = 1'b0; cfg_neuron = '0; cfg_slot = '0; cfg_sel = '0;
        in_valid = 1'b0; in_feat = '0; out_ready = 1'b0;
        cfg_we1 = 1'b0; cfg_neuron1 = '0; cfg_slot1 = '0; cfg_sel1 = '0;
        in_valid1 = 1'b0; in_feat1 = '0; out_ready1 = 1'b0;
        test_reset();
        test_single();
        test_routing();
        test_back_to_back();
        test_cfg_reject();
        test_reset_mid_run();
        test_n1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
